// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its debouncer.
// Press-vector bit 4*col+row maps to a hex code through KEY_MAP indexed by {row,col}.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    PRESSED
  } deb_state_t;

  typedef enum logic [1:0] {
    CAND_NONE,
    CAND_ONE,
    CAND_MULTI
  } cand_kind_t;

  // Element i is the code for {row,col} == i; listed from index 15 down to 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] press_to_code(input logic [3:0] bit_idx);
    logic [1:0] row;
    logic [1:0] col;
    row = bit_idx[1:0];
    col = bit_idx[3:2];
    return KEY_MAP[{row, col}];
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin group and decoded-key outputs shared between the scanner and its consumer.
// master = scanner side, slave = pin owner / display stage.
interface keypad_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_debounce.sv
// Per-sweep candidate debouncer: accepts a key after DEBOUNCE_SWEEPS identical sweeps.
// Latency: key_valid/key_held/key_code register one cycle after the candidate strobe.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cand_vld,
  input  cand_kind_t i_cand_kind,
  input  logic [3:0] i_cand_code,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_held
);

  localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SWEEPS);

  deb_state_t    r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_rel;

  logic          w_one;
  logic          w_same;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_rel_nxt;

  assign w_one     = (i_cand_kind == CAND_ONE);
  assign w_same    = w_one && (i_cand_code == r_cand);
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_rel_nxt = r_rel + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cand      <= 4'h0;
      r_cnt       <= '0;
      r_rel       <= '0;
      o_key_code  <= 4'h0;
      o_key_valid <= 1'b0;
      o_key_held  <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      if (i_cand_vld) begin
        unique case (r_state)
          IDLE: begin
            if (w_one) begin
              r_cand <= i_cand_code;
              r_cnt  <= CW'(1);
              if (LAST == CW'(1)) begin
                o_key_code  <= i_cand_code;
                o_key_valid <= 1'b1;
                o_key_held  <= 1'b1;
                r_rel       <= '0;
                r_state     <= PRESSED;
              end else begin
                r_state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (w_same) begin
              if (w_cnt_nxt == LAST) begin
                o_key_code  <= i_cand_code;
                o_key_valid <= 1'b1;
                o_key_held  <= 1'b1;
                r_rel       <= '0;
                r_state     <= PRESSED;
              end else begin
                r_cnt <= w_cnt_nxt;
              end
            end else if (w_one) begin
              r_cand <= i_cand_code;
              r_cnt  <= CW'(1);
            end else begin
              r_state <= IDLE;
            end
          end
          PRESSED: begin
            // A different single key counts toward release: no rollover.
            if (w_same || (i_cand_kind == CAND_MULTI)) begin
              r_rel <= '0;
            end else if (w_rel_nxt == LAST) begin
              r_rel      <= '0;
              o_key_held <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_rel <= w_rel_nxt;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: synchronizes rows, builds a per-sweep press vector, decodes it.
// Latency: key_valid pulses 1 cycle after the evaluation of the accepting sweep.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master kp
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  logic [NUM_ROWS-1:0]          r_row_s1;
  logic [NUM_ROWS-1:0]          r_row_s2;
  logic [DW-1:0]                r_dwell;
  logic [1:0]                   r_col;
  logic [NUM_COLS-1:0]          r_col_n;
  logic [NUM_COLS*NUM_ROWS-1:0] r_press;
  logic                         r_eval;

  logic       w_capture;
  logic [1:0] w_col_nxt;
  logic [4:0] w_hits;
  logic [3:0] w_idx;
  cand_kind_t w_kind;
  logic [3:0] w_code;

  assign w_capture = (r_dwell == DWELL_LAST);
  assign w_col_nxt = r_col + 2'd1;
  assign kp.col_n  = r_col_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
      r_dwell  <= '0;
      r_col    <= 2'd0;
      r_col_n  <= 4'b1110;
      r_press  <= '0;
      r_eval   <= 1'b0;
    end else begin
      r_row_s1 <= kp.row_n;
      r_row_s2 <= r_row_s1;
      r_eval   <= w_capture && (r_col == 2'd3);
      if (w_capture) begin
        r_dwell <= '0;
        r_col   <= w_col_nxt;
        r_col_n <= ~(4'b0001 << w_col_nxt);
        r_press[{r_col, 2'b00} +: NUM_ROWS] <= ~r_row_s2;
      end else begin
        r_dwell <= r_dwell + DW'(1);
        // The vector is fully consumed by the decode below during this cycle.
        if (r_eval) begin
          r_press <= '0;
        end
      end
    end
  end

  always_comb begin
    w_hits = 5'd0;
    w_idx  = 4'd0;
    for (int i = 0; i < NUM_COLS * NUM_ROWS; i++) begin
      if (r_press[i]) begin
        w_hits = w_hits + 5'd1;
        w_idx  = 4'(i);
      end
    end
    if (w_hits == 5'd0) begin
      w_kind = CAND_NONE;
    end else if (w_hits == 5'd1) begin
      w_kind = CAND_ONE;
    end else begin
      w_kind = CAND_MULTI;
    end
    w_code = press_to_code(w_idx);
  end

  keypad_debounce #(
    .DEBOUNCE_SWEEPS(DEBOUNCE_SWEEPS)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cand_vld (r_eval),
    .i_cand_kind(w_kind),
    .i_cand_code(w_code),
    .o_key_code (kp.key_code),
    .o_key_valid(kp.key_valid),
    .o_key_held (kp.key_held)
  );

endmodule
